serial_add_ctrl: RTL

Bit-serial adder/subtractor controller. It sequences a single full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first, with a registered carry. It provides a start/busy/done handshake so that upstream logic can share one full-adder cell for multi-bit add and subtract. It sits between the operand source (register file or control FSM) and the result consumer.

---
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell, LSB first, registered carry.
// Latency: WIDTH cycles from the start edge to the done pulse; one op per WIDTH+1 cycles.
// Backpressure: none; start is sampled only in IDLE or DONE and ignored while busy.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             carry;

    // Single full-adder cell working on the current LSBs and the carry flop
    logic bit_s;
    logic bit_c;
    logic last_bit;

    // Bit cell and last-bit detect
    always_comb begin
        bit_s    = sha[0] ^ shb[0] ^ carry;
        bit_c    = (sha[0] & shb[0]) | ((sha[0] ^ shb[0]) & carry);
        last_bit = (count == CW'(WIDTH - 1));
    end

    // Sequencer: operand latch, bit-serial datapath and registered outputs.
    // Outputs only move at the RUN->DONE edge so no partial sum is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sha    <= '0;
            shb    <= '0;
            acc    <= '0;
            count  <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B here, seed carry with 1
                        sha   <= op_a;
                        shb   <= sub ? ~op_b : op_b;
                        carry <= sub;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sha   <= sha >> 1;
                    shb   <= shb >> 1;
                    acc   <= {bit_s, acc[WIDTH-1:1]};
                    carry <= bit_c;
                    count <= count + CW'(1);
                    if (last_bit) begin
                        // carry still holds the carry into the MSB at this edge
                        result <= {bit_s, acc[WIDTH-1:1]};
                        cout   <= bit_c;
                        ovf    <= carry ^ bit_c;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
